mole_controller: RTL and testbench

Single-clock whack-a-mole engine that sits between the game-flow logic and the scoring stage. While a game is active, it picks pseudo-random mole positions and drives the 16 mole LEDs. It detects player whacks as toggles on the 16 slide switches. For each mole it emits exactly one outcome pulse: hit, miss, or none if the game is aborted. Its pulses feed the score counter directly, and the mode-rate tick it consumes comes from the clock divider as a one-cycle enable, not a derived clock.

---
 rtl/whack_pkg.sv | 24 ++
 rtl/mole_lfsr.sv | 29 ++
 rtl/mole_controller.sv | 167 ++++++++++++++++
 tb/tb_mole_controller.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole engine: FSM states, LFSR constants
// and board dimensions.
package whack_pkg;

    localparam int unsigned NUM_MOLES  = 16;
    localparam int unsigned MOLE_IDX_W = 4;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        UP,
        GAP
    } state_e;

    // One right-shift step of the Galois LFSR; a nonzero state never maps to zero.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick mole positions.
// Ports:
//   clock_i  - system clock
//   reset_i  - synchronous active-high reset, loads SEED
//   lfsr_o   - current LFSR state
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;

    // Advance every cycle outside reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_controller.sv
// Whack-a-mole engine: spawns pseudo-random moles while a game is active,
// detects whacks as switch toggles and emits one hit/miss pulse per mole.
// Ports:
//   clock_i        - system clock
//   reset_i        - synchronous active-high reset
//   game_active_i  - level, high during play; low forces IDLE
//   step_tick_i    - one-cycle enable at the difficulty rate
//   life_ticks_i   - step ticks a mole stays up (0 treated as 1)
//   switches_i     - raw slide switches (asynchronous)
//   moles_o        - one-hot lit mole or zero
//   hit_o/miss_o   - one-cycle outcome pulses for the current mole
//   wrong_o        - one-cycle pulse when a non-mole switch toggles while UP
module mole_controller #(
    parameter int unsigned NUM_MOLES = whack_pkg::NUM_MOLES,
    parameter logic [15:0] LFSR_SEED = whack_pkg::LFSR_SEED
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 game_active_i,
    input  logic                 step_tick_i,
    input  logic [3:0]           life_ticks_i,
    input  logic [NUM_MOLES-1:0] switches_i,
    output logic [NUM_MOLES-1:0] moles_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 wrong_o
);

    import whack_pkg::state_e;
    import whack_pkg::IDLE;
    import whack_pkg::SPAWN;
    import whack_pkg::UP;
    import whack_pkg::GAP;
    import whack_pkg::MOLE_IDX_W;
    import whack_pkg::LFSR_W;

    state_e                 state_q, state_d;
    logic [MOLE_IDX_W-1:0]  prev_idx_q, prev_idx_d;
    logic [3:0]             life_q, life_d;
    logic [NUM_MOLES-1:0]   moles_q, moles_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic                   wrong_q, wrong_d;

    logic [NUM_MOLES-1:0]   sw_meta_q, sw_sync_q, sw_hist_q;
    logic [NUM_MOLES-1:0]   whack;
    logic [LFSR_W-1:0]      lfsr_state;
    logic [MOLE_IDX_W-1:0]  spawn_idx;
    logic                   lfsr_unused;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .lfsr_o  (lfsr_state)
    );

    // Only the low bits pick the position; the rest just keep the sequence long.
    assign lfsr_unused = ^lfsr_state[LFSR_W-1:MOLE_IDX_W];

    // Synchronizer plus history; history tracks in every state so idle toggles vanish.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            sw_hist_q <= '0;
        end else begin
            sw_meta_q <= switches_i;
            sw_sync_q <= sw_meta_q;
            sw_hist_q <= sw_sync_q;
        end
    end

    // Either toggle direction counts as a whack.
    assign whack = sw_sync_q ^ sw_hist_q;

    // Never repeat the previous position back to back.
    always_comb begin
        spawn_idx = lfsr_state[MOLE_IDX_W-1:0];
        if (spawn_idx == prev_idx_q) begin
            spawn_idx = spawn_idx + MOLE_IDX_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            prev_idx_q <= '0;
            life_q     <= '0;
            moles_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            wrong_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_idx_q <= prev_idx_d;
            life_q     <= life_d;
            moles_q    <= moles_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            wrong_q    <= wrong_d;
        end
    end

    // Next-state and output logic; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        life_d     = life_q;
        moles_d    = moles_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        wrong_d    = 1'b0;

        if (!game_active_i) begin
            state_d = IDLE;
            moles_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    moles_d = '0;
                    state_d = SPAWN;
                end
                SPAWN: begin
                    prev_idx_d         = spawn_idx;
                    life_d             = (life_ticks_i == 4'd0) ? 4'd1 : life_ticks_i;
                    moles_d            = '0;
                    moles_d[spawn_idx] = 1'b1;
                    state_d            = UP;
                end
                UP: begin
                    wrong_d = |(whack & ~moles_q);
                    // A hit wins over a same-cycle expiry.
                    if (|(whack & moles_q)) begin
                        hit_d   = 1'b1;
                        moles_d = '0;
                        state_d = GAP;
                    end else if (step_tick_i) begin
                        life_d = life_q - 4'd1;
                        if (life_q == 4'd1) begin
                            miss_d  = 1'b1;
                            moles_d = '0;
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    moles_d = '0;
                    if (step_tick_i) begin
                        state_d = SPAWN;
                    end
                end
                default: begin
                    moles_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign moles_o = moles_q;
    assign hit_o   = hit_q;
    assign miss_o  = miss_q;
    assign wrong_o = wrong_q;

endmodule

// File: tb/tb_mole_controller.sv
`timescale 1ns/1ps
module tb_mole_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ga = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  lt = 4'd0;
    logic [15:0] sw = 16'h0;
    logic [15:0] moles_o;
    logic        hit_o, miss_o, wrong_o;

    int n_tests = 0;
    int n_fail  = 0;

    mole_controller dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .game_active_i (ga),
        .step_tick_i   (tick),
        .life_ticks_i  (lt),
        .switches_i    (sw),
        .moles_o       (moles_o),
        .hit_o         (hit_o),
        .miss_o        (miss_o),
        .wrong_o       (wrong_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] moles;
        logic        hit;
        logic        miss;
        logic        wrong;
    } ev_t;

    ev_t sbq[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model: tracks the game from the rules and queues every expected output event.
    int          cyc = 0;
    int          rst_cnt = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [15:0] h0 = 16'h0, h1 = 16'h0, h2 = 16'h0;
    bit          m_armed = 1'b0, m_lit = 1'b0, m_rest = 1'b0;
    int          m_idx = 0, m_prev = 0, m_need = 1, m_seen = 0;
    logic [15:0] last_exp = 16'h0;

    always @(posedge clk) begin : model
        logic [15:0] whack, exp_m;
        bit eh, em, ew;
        cyc++;
        eh = 1'b0; em = 1'b0; ew = 1'b0;
        whack = h1 ^ h2;
        if (rst) begin
            m_armed = 1'b0; m_lit = 1'b0; m_rest = 1'b0;
            m_prev = 0; m_lfsr = 16'hACE1;
            h0 = 16'h0; h1 = 16'h0; h2 = 16'h0;
            rst_cnt++;
        end else begin
            if (!ga) begin
                m_armed = 1'b0; m_lit = 1'b0; m_rest = 1'b0;
            end else if (m_armed) begin
                m_idx = int'(m_lfsr % 16'd16);
                if (m_idx == m_prev) m_idx = (m_idx + 1) % 16;
                m_prev = m_idx;
                m_need = (lt == 4'd0) ? 1 : int'(lt);
                m_seen = 0;
                m_lit = 1'b1; m_armed = 1'b0;
            end else if (m_lit) begin
                if ((whack & ~(16'(1) << m_idx)) != 16'h0) ew = 1'b1;
                if (whack[m_idx]) begin
                    eh = 1'b1; m_lit = 1'b0; m_rest = 1'b1;
                end else if (tick) begin
                    m_seen++;
                    if (m_seen >= m_need) begin
                        em = 1'b1; m_lit = 1'b0; m_rest = 1'b1;
                    end
                end
            end else if (m_rest) begin
                if (tick) begin m_rest = 1'b0; m_armed = 1'b1; end
            end else begin
                m_armed = 1'b1;
            end
            m_lfsr = lfsr_step(m_lfsr);
            h2 = h1; h1 = h0; h0 = sw;
        end
        exp_m = m_lit ? (16'(1) << m_idx) : 16'h0;
        if (eh || em || ew || exp_m != last_exp)
            sbq.push_back('{cyc, exp_m, eh, em, ew});
        last_exp = exp_m;
    end

    // Monitor: pops the next expected event whenever the DUT shows an output event.
    logic [15:0] last_act = 16'h0;
    int          dut_prev = 0;
    int          spawns = 0;
    int          rst_ack = 0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        ev_t e;
        int  ai;
        if (mon_en) begin
            if (rst_cnt != rst_ack) begin
                rst_ack = rst_cnt;
                dut_prev = 0;
            end
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL missed_event cyc=%0d: DUT showed nothing, required moles=%h hit=%b miss=%b wrong=%b",
                         e.cyc, e.moles, e.hit, e.miss, e.wrong);
            end
            if (hit_o || miss_o || wrong_o || moles_o != last_act) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d: got moles=%h hit=%b miss=%b wrong=%b, required no event",
                             cyc, moles_o, hit_o, miss_o, wrong_o);
                end else begin
                    e = sbq.pop_front();
                    if (e.cyc != cyc || e.moles != moles_o || e.hit != hit_o ||
                        e.miss != miss_o || e.wrong != wrong_o) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d: got moles=%h hit=%b miss=%b wrong=%b, required cyc=%0d moles=%h hit=%b miss=%b wrong=%b",
                                 cyc, moles_o, hit_o, miss_o, wrong_o, e.cyc, e.moles, e.hit, e.miss, e.wrong);
                    end
                end
                if (moles_o != 16'h0 && last_act == 16'h0) begin
                    n_tests++;
                    spawns++;
                    ai = 0;
                    for (int b = 0; b < 16; b++) if (moles_o[b]) ai = b;
                    if ($countones(moles_o) != 1 || ai == dut_prev) begin
                        n_fail++;
                        $display("FAIL spawn_repeat cyc=%0d: got moles=%h prev_idx=%0d, required one-hot differing from prev",
                                 cyc, moles_o, dut_prev);
                    end
                    dut_prev = ai;
                end
            end
            last_act = moles_o;
        end
    end

    task automatic run(input int n, input int tick_every);
        for (int i = 0; i < n; i++) begin
            tick = (tick_every > 0) && ((i % tick_every) == tick_every - 1);
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic wait_lit(input int max_cyc);
        int k;
        k = 0;
        while (!m_lit && k < max_cyc) begin
            tick = (k % 3) == 2;
            @(negedge clk);
            k++;
        end
        tick = 1'b0;
        if (!m_lit) begin
            n_tests++; n_fail++;
            $display("FAIL wait_lit: no mole after %0d cycles, required a lit mole", max_cyc);
        end
    endtask

    initial begin : stimulus
        int start, guard;
        rst = 1'b1; ga = 1'b1; lt = 4'd4; sw = 16'h0;
        // Reset held with the game active: all outputs must stay low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mon_en = 1'b1;
            n_tests++;
            if (moles_o != 16'h0 || hit_o || miss_o || wrong_o) begin
                n_fail++;
                $display("FAIL reset_outputs: got moles=%h hit=%b miss=%b wrong=%b, required all 0",
                         moles_o, hit_o, miss_o, wrong_o);
            end
        end
        rst = 1'b0;

        // Hit with life 4, then the next mole after a tick.
        wait_lit(20);
        sw = sw ^ (16'(1) << m_idx);
        run(6, 0);
        run(8, 3);

        // Miss with life 2, then life 0 acting as 1.
        lt = 4'd2;
        wait_lit(30);
        run(12, 3);
        lt = 4'd0;
        wait_lit(30);
        run(8, 3);

        // Several wrong bits in one cycle, then mole plus one wrong bit together.
        lt = 4'd8;
        wait_lit(30);
        sw = sw ^ (16'(1) << ((m_idx + 1) % 16)) ^ (16'(1) << ((m_idx + 5) % 16))
                ^ (16'(1) << ((m_idx + 9) % 16));
        run(5, 0);
        sw = sw ^ (16'(1) << m_idx) ^ (16'(1) << ((m_idx + 3) % 16));
        run(5, 0);

        // Mole edge lands on the same edge as the expiring tick.
        lt = 4'd1;
        wait_lit(30);
        sw = sw ^ (16'(1) << m_idx);
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        run(3, 0);

        // Abort while UP, then toggles in IDLE.
        lt = 4'd6;
        wait_lit(30);
        ga = 1'b0;
        @(negedge clk);
        sw = sw ^ 16'h0F0F;
        run(4, 2);
        sw = sw ^ 16'h00FF;
        run(6, 0);
        ga = 1'b1;
        run(5, 0);

        // Randomized play with occasional aborts and resets.
        for (int i = 0; i < 2000; i++) begin
            ga   = ($urandom % 150) != 0;
            rst  = ($urandom % 400) == 0;
            tick = ($urandom % 3) == 0;
            if (($urandom % 10) == 0) lt = 4'($urandom % 5);
            if (m_lit && ($urandom % 5) == 0) sw = sw ^ (16'(1) << m_idx);
            if (($urandom % 8) == 0) sw = sw ^ 16'($urandom % 65536) & 16'($urandom % 65536);
            @(negedge clk);
        end
        rst = 1'b0; tick = 1'b0; ga = 1'b1;

        // Long run of fast spawns to exercise the no-repeat rule.
        lt = 4'd1;
        tick = 1'b1;
        start = spawns;
        guard = 0;
        while (spawns - start < 1000 && guard < 10000) begin
            @(negedge clk);
            guard++;
        end
        tick = 1'b0;
        n_tests++;
        if (spawns - start < 1000) begin
            n_fail++;
            $display("FAIL spawn_count: got %0d spawns, required at least 1000", spawns - start);
        end

        ga = 1'b0;
        run(6, 0);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected events, required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
